// File: rtl/entrada_pkg.sv
// entrada_pkg: shared FSM state encoding and digit limit for the digit-entry front end
package entrada_pkg;
  typedef enum logic [1:0] {
    OCIOSO       = 2'd0,
    FILTRA_PRESS = 2'd1,
    PRESSIONADO  = 2'd2,
    FILTRA_SOLTA = 2'd3
  } estado_t;
  localparam logic [3:0] DIGITO_MAX = 4'd9;
endpackage

// File: rtl/sincronizador.sv
// sincronizador: W-bit two-flop synchroniser (ports: clk, reset async high, d raw in, q synchronised out)
module sincronizador #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta_q, sinc_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      meta_q <= '0;
      sinc_q <= '0;
    end else begin
      meta_q <= d;
      sinc_q <= meta_q;
    end
  assign q = sinc_q;
endmodule

// File: rtl/entrada_digito.sv
// entrada_digito: debounced digit entry (clk, reset async high, botao/chaves raw in; insere/numero/invalido/limpa out; optional timeout via ENTRADA_TIMEOUT_EN)
module entrada_digito
  import entrada_pkg::*;
#(
  parameter int DEBOUNCE_CICLOS = 4,
  parameter int TIMEOUT_CICLOS  = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       botao,
  input  logic [3:0] chaves,
  output logic       insere,
  output logic [3:0] numero,
  output logic       invalido,
  output logic       limpa
);
  localparam int CW = $clog2(DEBOUNCE_CICLOS + 1);
  logic          botao_s;
  logic [3:0]    chaves_s;
  estado_t       estado_q, estado_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          insere_q, insere_d, invalido_q, invalido_d;
  logic [3:0]    numero_q, numero_d;
  logic          fim_cnt, digito_ok;
  sincronizador #(.W(5)) u_sinc (
    .clk   (clk),
    .reset (reset),
    .d     ({botao, chaves}),
    .q     ({botao_s, chaves_s})
  );
  assign fim_cnt   = cnt_q == CW'(DEBOUNCE_CICLOS - 1);
  assign digito_ok = chaves_s <= DIGITO_MAX;
  always_comb begin
    estado_d   = estado_q;
    cnt_d      = cnt_q;
    insere_d   = 1'b0;
    invalido_d = 1'b0;
    numero_d   = numero_q;
    case (estado_q)
      OCIOSO:
        if (botao_s) begin
          estado_d = FILTRA_PRESS;
          cnt_d    = '0;
        end
      FILTRA_PRESS:
        if (!botao_s) estado_d = OCIOSO;
        else if (fim_cnt) begin
          // chaves is captured only here, at the acceptance edge
          estado_d   = PRESSIONADO;
          insere_d   = digito_ok;
          invalido_d = !digito_ok;
          numero_d   = digito_ok ? chaves_s : numero_q;
        end else cnt_d = cnt_q + CW'(1);
      PRESSIONADO:
        if (!botao_s) begin
          estado_d = FILTRA_SOLTA;
          cnt_d    = '0;
        end
      FILTRA_SOLTA:
        if (botao_s) estado_d = PRESSIONADO;
        else if (fim_cnt) estado_d = OCIOSO;
        else cnt_d = cnt_q + CW'(1);
      default: estado_d = OCIOSO;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      estado_q   <= OCIOSO;
      cnt_q      <= '0;
      insere_q   <= 1'b0;
      invalido_q <= 1'b0;
      numero_q   <= '0;
    end else begin
      estado_q   <= estado_d;
      cnt_q      <= cnt_d;
      insere_q   <= insere_d;
      invalido_q <= invalido_d;
      numero_q   <= numero_d;
    end
  assign insere   = insere_q;
  assign invalido = invalido_q;
  assign numero   = numero_q;
`ifdef ENTRADA_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CICLOS + 1);
  logic [TW-1:0] timer_q, timer_d;
  logic          ativo_q, ativo_d, limpa_q, limpa_d, expira;
  // the timer only advances while ativo, so gating by ativo keeps an idle lock quiet
  assign expira = ativo_q && timer_q == TW'(TIMEOUT_CICLOS - 1);
  always_comb begin
    timer_d = (insere_d || expira) ? '0 : ativo_q ? timer_q + TW'(1) : timer_q;
    ativo_d = insere_d || (ativo_q && !expira);
    limpa_d = expira && !insere_d;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      timer_q <= '0;
      ativo_q <= 1'b0;
      limpa_q <= 1'b0;
    end else begin
      timer_q <= timer_d;
      ativo_q <= ativo_d;
      limpa_q <= limpa_d;
    end
  assign limpa = limpa_q;
`else
  // always false; keeps the timeout parameter referenced in the lean build
  assign limpa = TIMEOUT_CICLOS < 0;
`endif
endmodule

// File: tb/tb_entrada_digito.sv
// tb_entrada_digito: directed self-checking bench for entrada_digito
module tb_entrada_digito;
  logic       clk = 1'b0;
  logic       reset, botao;
  logic [3:0] chaves;
  logic       insere, invalido, limpa;
  logic [3:0] numero;
  int ciclo = 0, n_ins = 0, n_inv = 0, n_limpa = 0, ambos = 0;
  int ult_ins = -1, ult_inv = -1, ult_limpa = -1;
  int compared = 0, mismatched = 0;
  entrada_digito dut (
    .clk      (clk),
    .reset    (reset),
    .botao    (botao),
    .chaves   (chaves),
    .insere   (insere),
    .numero   (numero),
    .invalido (invalido),
    .limpa    (limpa)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    #1;
    ciclo = ciclo + 1;
    if (insere) begin
      n_ins   = n_ins + 1;
      ult_ins = ciclo;
    end
    if (invalido) begin
      n_inv   = n_inv + 1;
      ult_inv = ciclo;
    end
    if (limpa) begin
      n_limpa   = n_limpa + 1;
      ult_limpa = ciclo;
    end
    if (insere && invalido) ambos = ambos + 1;
  end
  task automatic verifica(input string tag, input int obs, input int esp);
    compared = compared + 1;
    if (obs !== esp) begin
      mismatched = mismatched + 1;
      $display("FAIL %s: obtido=%0d esperado=%0d", tag, obs, esp);
    end
  endtask
  task automatic espera(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    int k, i0, v0, t;
`ifdef ENTRADA_TIMEOUT_EN
    int l0;
`endif
    reset  = 1'b1;
    botao  = 1'b0;
    chaves = 4'd0;
    #2;
    verifica("reset_insere", insere, 0);
    verifica("reset_numero", numero, 0);
    verifica("reset_invalido", invalido, 0);
    verifica("reset_limpa", limpa, 0);
    espera(3);
    reset = 1'b0;
    espera(3);
    // clean press, digit 5
    chaves = 4'd5;
    botao  = 1'b1;
    k  = ciclo + 1;
    i0 = n_ins;
    espera(20);
    botao = 1'b0;
    espera(12);
    verifica("t1_qtd", n_ins - i0, 1);
    verifica("t1_borda", ult_ins, k + 6);
    verifica("t1_numero", numero, 5);
    verifica("t1_inv", n_inv, 0);
    // out-of-range switches
    chaves = 4'd12;
    botao  = 1'b1;
    k  = ciclo + 1;
    i0 = n_ins;
    v0 = n_inv;
    espera(15);
    botao = 1'b0;
    espera(12);
    verifica("t3_inv_qtd", n_inv - v0, 1);
    verifica("t3_inv_borda", ult_inv, k + 6);
    verifica("t3_ins_qtd", n_ins - i0, 0);
    verifica("t3_numero", numero, 5);
    // press bounce then stable press, digit 3
    chaves = 4'd3;
    i0 = n_ins;
    for (int r = 0; r < 2; r++) begin
      botao = 1'b1;
      espera(2);
      botao = 1'b0;
      espera(2);
    end
    verifica("t2_bounce", n_ins - i0, 0);
    botao = 1'b1;
    k = ciclo + 1;
    espera(20);
    verifica("t2_qtd", n_ins - i0, 1);
    verifica("t2_borda", ult_ins, k + 6);
    verifica("t2_numero", numero, 3);
    // release bounce while held, then full release and new press
    i0 = n_ins;
    espera(5);
    botao = 1'b0;
    espera(2);
    botao = 1'b1;
    espera(10);
    verifica("t4_solta_bounce", n_ins - i0, 0);
    botao = 1'b0;
    espera(10);
    botao = 1'b1;
    k = ciclo + 1;
    espera(15);
    verifica("t4_qtd", n_ins - i0, 1);
    verifica("t4_borda", ult_ins, k + 6);
    botao = 1'b0;
    espera(12);
    // async reset mid FILTRA_PRESS
    chaves = 4'd7;
    botao  = 1'b1;
    i0 = n_ins;
    espera(3);
    #2 reset = 1'b1;
    #1;
    verifica("t5_rst_insere", insere, 0);
    verifica("t5_rst_numero", numero, 0);
    verifica("t5_rst_invalido", invalido, 0);
    verifica("t5_rst_limpa", limpa, 0);
    espera(2);
    reset = 1'b0;
    k = ciclo + 1;
    espera(15);
    verifica("t5_qtd", n_ins - i0, 1);
    verifica("t5_borda", ult_ins, k + 6);
    verifica("t5_numero", numero, 7);
    botao = 1'b0;
    espera(12);
`ifdef ENTRADA_TIMEOUT_EN
    l0 = n_limpa;
    chaves = 4'd2;
    botao  = 1'b1;
    espera(10);
    botao = 1'b0;
    t = ult_ins;
    while (ciclo < t + 70) espera(1);
    verifica("t6_limpa_qtd", n_limpa - l0, 1);
    verifica("t6_limpa_borda", ult_limpa, t + 64);
    chaves = 4'd4;
    botao  = 1'b1;
    espera(10);
    botao = 1'b0;
    t = ult_ins;
    l0 = n_limpa;
    while (ciclo < t + 56) espera(1);
    botao = 1'b1;
    espera(15);
    botao = 1'b0;
    while (ciclo < t + 70) espera(1);
    verifica("t6_segundo_borda", ult_ins, t + 63);
    verifica("t6_sem_limpa", n_limpa - l0, 0);
    while (ciclo < t + 135) espera(1);
    verifica("t6_limpa2_qtd", n_limpa - l0, 1);
    verifica("t6_limpa2_borda", ult_limpa, t + 127);
`else
    espera(200);
    verifica("t6_limpa_zero", n_limpa, 0);
`endif
    verifica("exclusivos", ambos, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/entrada_digito.md
Name: entrada_digito

Overview:
Front-end digit-entry stage for the code-lock FSM. Takes a raw pushbutton and 4 raw switches, synchronises and debounces them, and delivers exactly one single-cycle `insere` strobe with a held 4-bit `numero` per physical press. The code-checker FSM consumes this directly. Out-of-range switch values (>9) are rejected and flagged instead of forwarded.

Parameters:
DEBOUNCE_CICLOS, 4, consecutive stable cycles required to accept a press or a release (≥1; board build overrides to 500000)
TIMEOUT_CICLOS, 64, idle cycles after the last accepted digit before `limpa` fires (only with ENTRADA_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
botao  in  1  raw "insert" pushbutton, active-high, bouncy, asynchronous
chaves  in  4  raw digit switches, asynchronous
insere  out  1  one-cycle strobe: valid digit accepted
numero  out  4  last accepted digit (0..9), held between strobes
invalido  out  1  one-cycle strobe: press accepted but chaves > 9
limpa  out  1  one-cycle strobe: entry timeout (constant 0 without the macro)

Behaviour:
- Reset is asynchronous and active-high; one clock `clk`. While reset is high, all of the following are 0: sync flops, state (OCIOSO), counter, insere, numero, invalido, limpa, timer, ativo.
- botao and chaves pass through a 2-flop synchroniser, giving botao_s and chaves_s. No logic uses the raw inputs.
- FSM states:
  - OCIOSO: if botao_s=1, go to FILTRA_PRESS with cnt=0.
  - FILTRA_PRESS: if botao_s=0, go back to OCIOSO. Else, if cnt==DEBOUNCE_CICLOS-1, go to PRESSIONADO; otherwise cnt++.
  - PRESSIONADO: if botao_s=0, go to FILTRA_SOLTA with cnt=0.
  - FILTRA_SOLTA: if botao_s=1, go back to PRESSIONADO with no new strobe. Else, if cnt==DEBOUNCE_CICLOS-1, go to OCIOSO; otherwise cnt++.
- Strobe generation, on the edge that moves FILTRA_PRESS to PRESSIONADO:
  - If chaves_s≤9: insere←1 and numero←chaves_s.
  - Else: invalido←1 and numero is unchanged.
  - Both strobes clear on the following edge. insere and invalido are never high together.
- Latency: let k be the first edge at which raw botao=1 is sampled, with botao held stable. insere/invalido rise at edge k+DEBOUNCE_CICLOS+2.
- No auto-repeat: holding the button produces exactly one strobe. A new strobe needs the FSM to pass back through OCIOSO.
- chaves is sampled only at the acceptance edge. Switch changes while held are ignored.
- Counter width is $clog2(DEBOUNCE_CICLOS+1). The counter never wraps because the compare precedes the increment.
- Reset mid-operation: the FSM aborts to OCIOSO and no pending strobe survives. If botao is still high after reset is released, the press is re-debounced from scratch and strobes at edge r+DEBOUNCE_CICLOS+2, where r is the first edge after reset release.

Optional Feature:
Macro: ENTRADA_TIMEOUT_EN
- With the macro:
  - `ativo` sets on each insere. The timer clears to 0 on each insere and increments each edge while ativo=1.
  - When timer==TIMEOUT_CICLOS-1 and there is no insere on that edge: limpa←1 for one cycle, ativo←0, timer←0. So limpa rises at edge t+TIMEOUT_CICLOS, where t is the last insere edge.
  - If insere coincides with expiry, insere wins: timer restarts and there is no limpa.
  - invalido does not touch the timer.
- Without the macro: limpa is tied to 0 and no timer or ativo logic is synthesised. The port list is identical in both builds.

Decomposition:
- Package entrada_pkg holds:
  - the state encoding localparams OCIOSO=2'd0, FILTRA_PRESS=2'd1, PRESSIONADO=2'd2, FILTRA_SOLTA=2'd3;
  - DIGITO_MAX=4'd9.
- One sub-module: sincronizador. It is a parameter-width (W) 2-flop synchroniser with async reset to 0, instantiated once with W=5 for {botao, chaves}.
- Debounce FSM, strobes and timeout live in entrada_digito.

Test Plan:
1. chaves=5, botao held high for 20 cycles from edge k → insere=1 for exactly one cycle at edge k+6, numero=5, invalido=0, then no further strobes.
2. chaves=3, botao bounces 1,0,1,0 (2 cycles each), then stays high for 20 cycles → exactly one insere, numero=3, and no strobe during the bounce.
3. After test 1, chaves=12 and a clean press → invalido=1 for one cycle, insere=0, numero stays 5.
4. Release bounce: hold, then drop botao for 2 cycles, then back high for 10 cycles → no second insere. A full release of ≥6 cycles followed by a new press → second insere.
5. Assert reset asynchronously mid-FILTRA_PRESS with botao high → all outputs 0 immediately. Release reset at edge r with botao still high → insere at edge r+6.
6. ENTRADA_TIMEOUT_EN defined: one digit at edge t, then idle → limpa for one cycle at edge t+64. A second digit at t+63 gives no limpa at t+64. Macro undefined: limpa stays 0 for 200 idle cycles.
